// File: rtl/alu_result_sequencer.sv
// ALU result sequencer: enables one function unit, waits for relay
// settle, then latches the result into A or D and updates flags.
module alu_result_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       func_sel,
  input  logic             dest_sel,
  input  logic [WIDTH-1:0] fn_result,
  input  logic             carry_in,
  output logic [6:0]       en_fn,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_d,
  output logic             flag_sign,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LATCH
  } state_t;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_INC = 3'd1;
  localparam logic [2:0] FN_CLR = 3'd7;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [2:0] func_q;
  logic dest_q;
  logic accept, capture;
  logic [WIDTH-1:0] res;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          cnt_nx   = CNT_LOAD;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nx = LATCH;
        else cnt_nx = cnt - 4'd1;
      end
      LATCH: begin
        capture  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Enables derive from the registered state, so reset drops them at once
  assign busy  = (state != IDLE);
  assign en_fn = (busy && func_q != FN_CLR) ? (7'd1 << func_q) : 7'd0;
  assign res   = (func_q == FN_CLR) ? '0 : fn_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      func_q     <= 3'd0;
      dest_q     <= 1'b0;
      reg_a      <= '0;
      reg_d      <= '0;
      flag_sign  <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= capture;
      if (accept) begin
        func_q <= func_sel;
        dest_q <= dest_sel;
      end
      if (capture) begin
        if (dest_q) reg_d <= res;
        else reg_a <= res;
        flag_sign  <= res[WIDTH-1];
        flag_zero  <= (res == '0);
        flag_carry <= (func_q == FN_ADD || func_q == FN_INC) && carry_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Randomized self-checking bench for alu_result_sequencer against a
// cycle-schedule reference model.
module tb_alu_result_sequencer;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   func_sel;
  logic         dest_sel;
  logic [W-1:0] fn_result;
  logic         carry_in;
  logic [6:0]   en_fn;
  logic [W-1:0] reg_a, reg_d;
  logic         flag_sign, flag_carry, flag_zero, busy, done;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_a, m_d;
  logic m_sign, m_carry, m_zero;

  logic [6:0] obs_en[0:15];
  logic       obs_done[0:15];
  logic       obs_busy[0:15];

  alu_result_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start),
    .func_sel(func_sel), .dest_sel(dest_sel),
    .fn_result(fn_result), .carry_in(carry_in),
    .en_fn(en_fn), .reg_a(reg_a), .reg_d(reg_d),
    .flag_sign(flag_sign), .flag_carry(flag_carry),
    .flag_zero(flag_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] onehot(input logic [2:0] f);
    return (f == 3'd7) ? 7'd0 : 7'(1 << f);
  endfunction

  function automatic void model_op(input logic [2:0] f, input logic dst,
                                   input logic [W-1:0] data, input logic cin);
    logic [W-1:0] v;
    v = (f == 3'd7) ? '0 : data;
    if (dst) m_d = v;
    else m_a = v;
    m_sign  = v[W-1];
    m_zero  = (v == '0);
    m_carry = (f == 3'd0 || f == 3'd1) ? cin : 1'b0;
  endfunction

  // Starts one op from IDLE, logs cycles 1..S+2, returns in cycle S+2
  task automatic run_op(input logic [2:0] f, input logic dst,
                        input logic [W-1:0] data, input logic cin);
    func_sel  = f;
    dest_sel  = dst;
    fn_result = data;
    carry_in  = cin;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    func_sel = 3'($urandom);
    dest_sel = 1'($urandom);
    for (int c = 1; c <= S + 2; c++) begin
      obs_en[c]   = en_fn;
      obs_done[c] = done;
      obs_busy[c] = busy;
      if (c < S + 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; func_sel = 3'd0; dest_sel = 1'b0;
    fn_result = '0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_a = '0; m_d = '0; m_sign = 0; m_carry = 0; m_zero = 0;
    checks++; if (en_fn !== 7'd0) begin failures++; $display("FAIL reset_en got=%h exp=00", en_fn); end
    checks++; if (reg_a !== '0) begin failures++; $display("FAIL reset_a got=%h exp=00", reg_a); end
    checks++; if (reg_d !== '0) begin failures++; $display("FAIL reset_d got=%h exp=00", reg_d); end
    checks++; if ({flag_sign, flag_carry, flag_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {flag_sign, flag_carry, flag_zero}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    func_sel = 3'd1; dest_sel = 1'b0; fn_result = 8'hA5; carry_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (en_fn !== onehot(3'd1)) begin
      failures++; $display("FAIL abort_en_pre got=%h exp=%h", en_fn, onehot(3'd1)); end
    reset = 1'b1;
    #1;
    checks++; if (en_fn !== 7'd0) begin failures++; $display("FAIL abort_en_drop got=%h exp=00", en_fn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < S + 3; i++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done i=%0d got=%b exp=0", i, done); end
      @(posedge clk); #1;
    end
    checks++; if ({reg_a, reg_d} !== '0) begin
      failures++; $display("FAIL abort_regs got=%h/%h exp=00/00", reg_a, reg_d); end
    checks++; if ({flag_sign, flag_carry, flag_zero} !== 3'b000) begin
      failures++; $display("FAIL abort_flags got=%b exp=000", {flag_sign, flag_carry, flag_zero}); end
    run_op(3'd1, 1'b1, 8'h7F, 1'b1);
    model_op(3'd1, 1'b1, 8'h7F, 1'b1);
    checks++; if (obs_done[S+2] !== 1'b1) begin failures++; $display("FAIL abort_next_done got=%b exp=1", obs_done[S+2]); end
    checks++; if (reg_d !== m_d || flag_carry !== m_carry) begin
      failures++; $display("FAIL abort_next_d got=%h/%b exp=%h/%b", reg_d, flag_carry, m_d, m_carry); end
  endtask

  task automatic test_shl;
    run_op(3'd6, 1'b0, 8'h81, 1'b0);
    model_op(3'd6, 1'b0, 8'h81, 1'b0);
    for (int c = 1; c <= S + 2; c++) begin
      checks++; if (obs_en[c] !== ((c <= S + 1) ? onehot(3'd6) : 7'd0)) begin
        failures++; $display("FAIL shl_en c=%0d got=%h", c, obs_en[c]); end
      checks++; if (obs_done[c] !== (c == S + 2)) begin
        failures++; $display("FAIL shl_done c=%0d got=%b exp=%b", c, obs_done[c], c == S + 2); end
    end
    checks++; if (reg_a !== m_a || reg_d !== m_d) begin
      failures++; $display("FAIL shl_regs got=%h/%h exp=%h/%h", reg_a, reg_d, m_a, m_d); end
    checks++; if ({flag_sign, flag_carry, flag_zero} !== {m_sign, m_carry, m_zero}) begin
      failures++; $display("FAIL shl_flags got=%b exp=%b", {flag_sign, flag_carry, flag_zero}, {m_sign, m_carry, m_zero}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || en_fn !== 7'd0) begin
      failures++; $display("FAIL shl_after got=%b/%h exp=0/00", done, en_fn); end
  endtask

  task automatic test_add_xor;
    run_op(3'd0, 1'b1, 8'h00, 1'b1);
    model_op(3'd0, 1'b1, 8'h00, 1'b1);
    checks++; if (reg_d !== m_d) begin failures++; $display("FAIL add_d got=%h exp=%h", reg_d, m_d); end
    checks++; if ({flag_sign, flag_carry, flag_zero} !== {m_sign, m_carry, m_zero}) begin
      failures++; $display("FAIL add_flags got=%b exp=%b", {flag_sign, flag_carry, flag_zero}, {m_sign, m_carry, m_zero}); end
    run_op(3'd4, 1'b1, 8'h5A, 1'b1);
    model_op(3'd4, 1'b1, 8'h5A, 1'b1);
    checks++; if (reg_d !== m_d) begin failures++; $display("FAIL xor_d got=%h exp=%h", reg_d, m_d); end
    checks++; if ({flag_sign, flag_carry, flag_zero} !== {m_sign, m_carry, m_zero}) begin
      failures++; $display("FAIL xor_flags got=%b exp=%b", {flag_sign, flag_carry, flag_zero}, {m_sign, m_carry, m_zero}); end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    int nbusy = 0;
    int dcyc = -1;
    func_sel = 3'd6; dest_sel = 1'b0; fn_result = 8'h3C; carry_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 2 || c == 3);
      if (done) begin ndone++; dcyc = c; end
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    model_op(3'd6, 1'b0, 8'h3C, 1'b0);
    checks++; if (ndone != 1) begin failures++; $display("FAIL ign_ndone got=%0d exp=1", ndone); end
    checks++; if (dcyc != S + 2) begin failures++; $display("FAIL ign_dcyc got=%0d exp=%0d", dcyc, S + 2); end
    checks++; if (nbusy != S + 1) begin failures++; $display("FAIL ign_busy got=%0d exp=%0d", nbusy, S + 1); end
    checks++; if (reg_a !== m_a) begin failures++; $display("FAIL ign_a got=%h exp=%h", reg_a, m_a); end
  endtask

  task automatic test_clr;
    checks++; if (reg_a !== m_a) begin failures++; $display("FAIL clr_pre_a got=%h exp=%h", reg_a, m_a); end
    run_op(3'd7, 1'b0, 8'hFF, 1'b1);
    model_op(3'd7, 1'b0, 8'hFF, 1'b1);
    for (int c = 1; c <= S + 2; c++) begin
      checks++; if (obs_en[c] !== 7'd0) begin failures++; $display("FAIL clr_en c=%0d got=%h exp=00", c, obs_en[c]); end
      checks++; if (obs_busy[c] !== (c <= S + 1)) begin
        failures++; $display("FAIL clr_busy c=%0d got=%b exp=%b", c, obs_busy[c], c <= S + 1); end
    end
    checks++; if (obs_done[S+2] !== 1'b1) begin failures++; $display("FAIL clr_done got=%b exp=1", obs_done[S+2]); end
    checks++; if (reg_a !== m_a) begin failures++; $display("FAIL clr_a got=%h exp=%h", reg_a, m_a); end
    checks++; if ({flag_sign, flag_carry, flag_zero} !== {m_sign, m_carry, m_zero}) begin
      failures++; $display("FAIL clr_flags got=%b exp=%b", {flag_sign, flag_carry, flag_zero}, {m_sign, m_carry, m_zero}); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp_en;
    func_sel = 3'd0; dest_sel = 1'b0; fn_result = 8'h11; carry_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 11; c++) begin
      start = (c < 10);
      if (c == 3) func_sel = 3'd3;
      if (c == 5) begin fn_result = 8'h80; carry_in = 1'b1; end
      if (c >= 1 && c <= S + 1) exp_en = onehot(3'd0);
      else if (c >= S + 3 && c <= 2 * S + 3) exp_en = onehot(3'd3);
      else exp_en = 7'd0;
      checks++; if (en_fn !== exp_en) begin failures++; $display("FAIL b2b_en c=%0d got=%h exp=%h", c, en_fn, exp_en); end
      checks++; if (done !== (c == S + 2 || c == 2 * S + 4)) begin
        failures++; $display("FAIL b2b_done c=%0d got=%b", c, done); end
      if (c == S + 2) begin
        model_op(3'd0, 1'b0, 8'h11, 1'b1);
        checks++; if (reg_a !== m_a || flag_carry !== m_carry) begin
          failures++; $display("FAIL b2b_op1 got=%h/%b exp=%h/%b", reg_a, flag_carry, m_a, m_carry); end
      end
      if (c == 2 * S + 4) begin
        model_op(3'd3, 1'b0, 8'h80, 1'b1);
        checks++; if (reg_a !== m_a || {flag_sign, flag_carry, flag_zero} !== {m_sign, m_carry, m_zero}) begin
          failures++; $display("FAIL b2b_op2 got=%h/%b exp=%h/%b", reg_a,
            {flag_sign, flag_carry, flag_zero}, m_a, {m_sign, m_carry, m_zero}); end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0]   f;
    logic         dst;
    logic [W-1:0] data;
    logic         cin;
    for (int n = 0; n < 30; n++) begin
      f = 3'($urandom); dst = 1'($urandom); data = W'($urandom); cin = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      run_op(f, dst, data, cin);
      model_op(f, dst, data, cin);
      for (int c = 1; c <= S + 2; c++) begin
        checks++; if (obs_en[c] !== ((c <= S + 1) ? onehot(f) : 7'd0) || obs_done[c] !== (c == S + 2)) begin
          failures++; $display("FAIL rnd_cyc n=%0d c=%0d got=%h/%b f=%0d", n, c, obs_en[c], obs_done[c], f); end
      end
      checks++; if (reg_a !== m_a || reg_d !== m_d) begin
        failures++; $display("FAIL rnd_regs n=%0d got=%h/%h exp=%h/%h", n, reg_a, reg_d, m_a, m_d); end
      checks++; if ({flag_sign, flag_carry, flag_zero} !== {m_sign, m_carry, m_zero}) begin
        failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n,
          {flag_sign, flag_carry, flag_zero}, {m_sign, m_carry, m_zero}); end
    end
  endtask

  initial begin
    test_reset;
    test_reset_abort;
    test_shl;
    test_add_xor;
    test_start_ignored;
    test_clr;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_sequencer.md
Name: alu_result_sequencer

Overview:
- Control stage directly downstream of the ALU function units: the shift-left-circular unit, the adder, the logic units and the incrementer.
- Selects one function, enables its relays, and waits a fixed settle time to model relay contact bounce.
- Latches the settled result into destination register A or D, and updates the sign, carry and zero condition flags.
- The instruction sequencer drives it with a start/done handshake.

Parameters:
- WIDTH, 8, data width of function results and destination registers.
- SETTLE_CYCLES, 3, clock cycles the function enable is held before capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one ALU operation; sampled only in IDLE.
- func_sel  in  3  function code: 000 add, 001 inc, 010 and, 011 or, 100 xor, 101 not, 110 shl, 111 clr.
- dest_sel  in  1  destination register: 0 = A, 1 = D.
- fn_result  in  WIDTH  OR-combined output bus of all ALU function units.
- carry_in  in  1  carry-out from the adder/incrementer.
- en_fn  out  7  one-hot function enables: bit0 add, bit1 inc, bit2 and, bit3 or, bit4 xor, bit5 not, bit6 shl (bit6 drives en_shl).
- reg_a  out  WIDTH  register A.
- reg_d  out  WIDTH  register D.
- flag_sign  out  1  sign flag, equal to bit WIDTH-1 of the last latched result.
- flag_carry  out  1  carry flag.
- flag_zero  out  1  zero flag, set when the last latched result is all zero.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; en_fn = 0; reg_a = 0; reg_d = 0.
  - All flags = 0; busy = 0; done = 0.
- States: IDLE, SETTLE, LATCH.
- IDLE:
  - On start = 1, register func_sel and dest_sel and load the settle counter with SETTLE_CYCLES - 1; go to SETTLE.
  - Otherwise remain in IDLE.
- SETTLE:
  - en_fn is the one-hot decode of the captured func_sel; func 111 gives en_fn = 0.
  - busy = 1.
  - The counter decrements each cycle; at 0, go to LATCH.
  - Occupancy is exactly SETTLE_CYCLES cycles.
- LATCH (one cycle):
  - en_fn stays asserted; busy = 1.
  - At the closing clock edge:
    - The destination register captures fn_result; for func 111 it captures 0.
    - flag_sign and flag_zero are computed from the captured value.
    - flag_carry = carry_in for add/inc, and 0 for all other functions.
  - done registers to 1; state goes to IDLE.
- Timing, with the start edge at cycle 0:
  - SETTLE occupies cycles 1..S and LATCH is cycle S+1.
  - done is high for exactly cycle S+2, coinciding with the updated register and flags.
  - en_fn returns to 0 in cycle S+2.
- Back-to-back: start asserted in cycle S+2 is accepted; there are no dead cycles.
- start during SETTLE or LATCH is ignored and not queued.
- func_sel and dest_sel are sampled only at acceptance; changes mid-operation have no effect.
- The non-destination register and all state not named above hold their values.
- Reset asserted in SETTLE or LATCH aborts the operation:
  - No register capture and no done pulse.
  - en_fn drops to 0 without waiting for a clock.
- en_fn never has more than one bit set.

Test Plan:
- Reset, then shl with fn_result = 0x81 to A, SETTLE_CYCLES = 3:
  - en_fn = 0x40 during cycles 1..4.
  - done in cycle 5 only; reg_a = 0x81.
  - sign = 1, zero = 0, carry = 0; reg_d unchanged at 0x00.
- add to D with fn_result = 0x00 and carry_in = 1:
  - reg_d = 0x00, zero = 1, carry = 1, sign = 0.
  - Follow with an xor to D (fn_result = 0x5A, carry_in = 1): carry = 0, zero = 0, reg_d = 0x5A.
- start pulsed in cycles 2 and 3 of a shl operation: exactly one done pulse, one capture, and no extra SETTLE entry.
- Reset asserted in cycle 2 of an inc operation:
  - en_fn = 0 within the same cycle; registers and flags remain 0.
  - No done pulse; the next start is accepted normally.
- clr to A after reg_a = 0x3C, with fn_result = 0xFF driven as noise:
  - en_fn stays 0 throughout; reg_a = 0x00; zero = 1.
- Back-to-back operations with start held high continuously:
  - done pulses in cycles 5 and 10.
  - func_sel changed mid-operation is ignored until the second acceptance.
